// File: rtl/kamacore_stage_if_if.sv
// Fetch-stage bundle: instruction-memory request/response, redirect input and the IF/ID output.
// The fetch stage is the master; the memory, the later stages and the decode stage form the slave.
interface kamacore_stage_if_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instruction;

    modport master (
        output imem_req_valid, imem_req_addr, if_id_valid, if_id_pc, if_id_instruction,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, if_id_valid, if_id_pc, if_id_instruction,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/kamacore_stage_if.sv
// Instruction fetch stage: credit-limited in-order fetcher feeding a small buffer that drives IF/ID.
// Redirects empty the buffer and mark in-flight responses to be dropped as they return.
module kamacore_stage_if #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSN   = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst,
    kamacore_stage_if_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_X = (CW+1)'(FIFO_DEPTH);

    typedef enum logic {BOOT, FETCH} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
    logic [AW-1:0] bw_q, bw_d, br_q, br_d;
    logic [31:0]   pq_q       [FIFO_DEPTH];
    logic [31:0]   pq_d       [FIFO_DEPTH];
    logic [31:0]   buf_pc_q   [FIFO_DEPTH];
    logic [31:0]   buf_pc_d   [FIFO_DEPTH];
    logic [31:0]   buf_insn_q [FIFO_DEPTH];
    logic [31:0]   buf_insn_d [FIFO_DEPTH];

    logic redir, credit, req_valid, hs, rsp_take, keep, head_valid, pop;

    assign redir      = bus.redirect_valid;
    // Credit counts words in flight plus words buffered, so a response always has a slot.
    assign credit     = ({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH_X;
    assign req_valid  = (state_q == FETCH) && !redir && credit;
    assign hs         = req_valid && bus.imem_req_ready;
    // Responses with nothing in flight (e.g. stragglers from before a reset) are ignored.
    assign rsp_take   = bus.imem_rsp_valid && (outstanding_q != '0);
    assign keep       = rsp_take && (drop_q == '0) && !redir;
    assign head_valid = (count_q != '0) && !redir;
    assign pop        = head_valid && bus.id_ready;

    assign bus.imem_req_valid    = req_valid;
    assign bus.imem_req_addr     = pc_q;
    assign bus.if_id_valid       = head_valid;
    assign bus.if_id_pc          = head_valid ? buf_pc_q[br_q]   : 32'h0;
    assign bus.if_id_instruction = head_valid ? buf_insn_q[br_q] : NOP_INSN;

    always_comb begin
        state_d       = (state_q == BOOT) ? FETCH : state_q;
        pc_d          = pc_q;
        pq_d          = pq_q;
        pq_wr_d       = pq_wr_q;
        pq_rd_d       = pq_rd_q;
        outstanding_d = outstanding_q + CW'(hs) - CW'(rsp_take);
        drop_d        = drop_q;
        buf_pc_d      = buf_pc_q;
        buf_insn_d    = buf_insn_q;
        bw_d          = bw_q;
        br_d          = br_q;
        count_d       = count_q;

        if (redir)
            pc_d = bus.redirect_pc & ~32'h3;
        else if (hs)
            pc_d = pc_q + 32'd4;

        if (hs) begin
            pq_d[pq_wr_q] = pc_q;
            pq_wr_d       = pq_wr_q + 1'b1;
        end
        if (rsp_take)
            pq_rd_d = pq_rd_q + 1'b1;

        // Everything still in flight after this cycle belongs to the abandoned path.
        if (redir)
            drop_d = outstanding_q - CW'(rsp_take);
        else if (rsp_take && (drop_q != '0))
            drop_d = drop_q - 1'b1;

        if (redir) begin
            bw_d    = '0;
            br_d    = '0;
            count_d = '0;
        end else begin
            if (keep) begin
                buf_pc_d[bw_q]   = pq_q[pq_rd_q];
                buf_insn_d[bw_q] = bus.imem_rsp_data;
                bw_d             = bw_q + 1'b1;
            end
            if (pop)
                br_d = br_q + 1'b1;
            count_d = count_q + CW'(keep) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        pq_q       <= pq_d;
        buf_pc_q   <= buf_pc_d;
        buf_insn_q <= buf_insn_d;
        if (!rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            pq_wr_q       <= '0;
            pq_rd_q       <= '0;
            bw_q          <= '0;
            br_q          <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            pq_wr_q       <= pq_wr_d;
            pq_rd_q       <= pq_rd_d;
            bw_q          <= bw_d;
            br_q          <= br_d;
        end
    end
endmodule

// File: tb/tb_kamacore_stage_if.sv
// Bench for kamacore_stage_if: in-order latency memory model plus a sequential-PC reference stream.
module tb_kamacore_stage_if;
    localparam int          D   = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    kamacore_stage_if_if bus();

    kamacore_stage_if #(.RESET_PC(32'h0), .FIFO_DEPTH(D), .NOP_INSN(NOP)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_due = 0;
    int lat_min = 1, lat_max = 1;
    logic [31:0] mq_addr [$];
    int          mq_due  [$];
    bit          rsp_pop;
    logic [31:0] exp_fetch, exp_pres;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Drive one cycle's inputs just after a falling edge; the memory returns its head word when due.
    task automatic begin_cycle(input bit rdy, input bit idr, input bit rv, input logic [31:0] rpc);
        rsp_pop = 0;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            rsp_pop = 1;
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memf(mq_addr[0]);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        bus.imem_req_ready = rdy;
        bus.id_ready       = idr;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        #1;
    endtask

    // Advance memory and reference model, then move to the next falling edge.
    task automatic end_cycle();
        if (rsp_pop) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready === 1'b1) begin
            int d;
            d = cyc + int'($urandom_range(lat_max, lat_min));
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mq_addr.push_back(bus.imem_req_addr);
            mq_due.push_back(d);
        end
        if (bus.redirect_valid) begin
            exp_fetch = bus.redirect_pc & ~32'h3;
            exp_pres  = bus.redirect_pc & ~32'h3;
        end else begin
            if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready === 1'b1) exp_fetch += 32'd4;
            if (bus.if_id_valid === 1'b1 && bus.id_ready === 1'b1) exp_pres += 32'd4;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic flush_mem();
        mq_addr.delete();
        mq_due.delete();
        exp_fetch = 32'h0;
        exp_pres  = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        begin_cycle(1, 1, 0, 0); end_cycle();
        begin_cycle(1, 1, 0, 0);
        n_tests++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid got %b want 0", bus.imem_req_valid); end
        n_tests++; if (bus.if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_if_id_valid got %b want 0", bus.if_id_valid); end
        n_tests++; if (bus.if_id_pc !== 32'h0) begin n_fail++; $display("FAIL rst_if_id_pc got %h want 0", bus.if_id_pc); end
        n_tests++; if (bus.if_id_instruction !== NOP) begin n_fail++; $display("FAIL rst_insn got %h want %h", bus.if_id_instruction, NOP); end
        end_cycle();
        rst = 1'b1;
        flush_mem();
        lat_min = 1; lat_max = 1;
        for (int c = 0; c < 12; c++) begin
            begin_cycle(1, 1, 0, 0);
            if (c == 0) begin
                n_tests++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL boot_no_req got %b want 0", bus.imem_req_valid); end
            end else begin
                n_tests++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'(4*(c-1))) begin n_fail++; $display("FAIL seq_req c=%0d got v=%b a=%h want v=1 a=%h", c, bus.imem_req_valid, bus.imem_req_addr, 32'(4*(c-1))); end
            end
            if (c >= 3) begin
                n_tests++; if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== 32'(4*(c-3)) || bus.if_id_instruction !== memf(32'(4*(c-3)))) begin n_fail++; $display("FAIL seq_out c=%0d got v=%b pc=%h i=%h want pc=%h", c, bus.if_id_valid, bus.if_id_pc, bus.if_id_instruction, 32'(4*(c-3))); end
            end else begin
                n_tests++; if (bus.if_id_valid !== 1'b0) begin n_fail++; $display("FAIL seq_fill c=%0d got v=%b want 0", c, bus.if_id_valid); end
            end
            end_cycle();
        end
    endtask

    task automatic test_backpressure();
        lat_min = 1; lat_max = 3;
        for (int c = 0; c < 10; c++) begin
            begin_cycle(1, 0, 0, 0);
            n_tests++; if (bus.if_id_valid === 1'b1 && bus.if_id_pc !== exp_pres) begin n_fail++; $display("FAIL bp_hold got %h want %h", bus.if_id_pc, exp_pres); end
            n_tests++; if (mq_addr.size() > D) begin n_fail++; $display("FAIL bp_inflight got %0d want <=%0d", mq_addr.size(), D); end
            if (c == 9) begin
                n_tests++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_stop got %b want 0", bus.imem_req_valid); end
                n_tests++; if (bus.if_id_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full_valid got %b want 1", bus.if_id_valid); end
            end
            end_cycle();
        end
        for (int c = 0; c < 20; c++) begin
            begin_cycle(1, 1, 0, 0);
            n_tests++; if (bus.if_id_valid === 1'b1 && (bus.if_id_pc !== exp_pres || bus.if_id_instruction !== memf(exp_pres))) begin n_fail++; $display("FAIL bp_resume got pc=%h i=%h want pc=%h", bus.if_id_pc, bus.if_id_instruction, exp_pres); end
            n_tests++; if (bus.imem_req_valid === 1'b1 && bus.imem_req_addr !== exp_fetch) begin n_fail++; $display("FAIL bp_req_addr got %h want %h", bus.imem_req_addr, exp_fetch); end
            end_cycle();
        end
    endtask

    // Redirect and then confirm the first two presented PCs come from the new path.
    task automatic redirect_and_follow(input bit rdy_n, input logic [31:0] tgt, input logic [31:0] want);
        logic [31:0] seen [$];
        begin_cycle(rdy_n, 1, 1, tgt);
        n_tests++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_no_req got %b want 0", bus.imem_req_valid); end
        n_tests++; if (bus.if_id_valid !== 1'b0 || bus.if_id_instruction !== NOP) begin n_fail++; $display("FAIL redir_out got v=%b i=%h want v=0 i=%h", bus.if_id_valid, bus.if_id_instruction, NOP); end
        end_cycle();
        begin_cycle(1, 1, 0, 0);
        n_tests++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== want) begin n_fail++; $display("FAIL redir_first_req got v=%b a=%h want v=1 a=%h", bus.imem_req_valid, bus.imem_req_addr, want); end
        end_cycle();
        for (int c = 0; c < 20; c++) begin
            begin_cycle(1, 1, 0, 0);
            if (bus.if_id_valid === 1'b1) seen.push_back(bus.if_id_pc);
            n_tests++; if (bus.if_id_valid === 1'b1 && (bus.if_id_pc !== exp_pres || bus.if_id_instruction !== memf(exp_pres))) begin n_fail++; $display("FAIL redir_stream got pc=%h i=%h want pc=%h", bus.if_id_pc, bus.if_id_instruction, exp_pres); end
            end_cycle();
        end
        n_tests++; if (seen.size() < 2 || seen[0] !== want || seen[1] !== want + 32'd4) begin n_fail++; $display("FAIL redir_first_two got n=%0d want %h,%h", seen.size(), want, want + 32'd4); end
    endtask

    task automatic test_redirect();
        int guard = 0;
        lat_min = 3; lat_max = 3;
        while (mq_addr.size() < 2 && guard < 20) begin begin_cycle(1, 1, 0, 0); end_cycle(); guard++; end
        n_tests++; if (mq_addr.size() < 2) begin n_fail++; $display("FAIL redir_setup got %0d in flight want >=2", mq_addr.size()); end
        redirect_and_follow(1, 32'h0000_0100, 32'h0000_0100);
    endtask

    task automatic test_redirect_rsp();
        int guard = 0;
        lat_min = 2; lat_max = 2;
        while (!(mq_addr.size() > 0 && mq_due[0] <= cyc) && guard < 20) begin begin_cycle(1, 1, 0, 0); end_cycle(); guard++; end
        n_tests++; if (!(mq_addr.size() > 0 && mq_due[0] <= cyc)) begin n_fail++; $display("FAIL redir_rsp_setup got no due response want one"); end
        redirect_and_follow(0, 32'h0000_0203, 32'h0000_0200);
    endtask

    task automatic test_wrap();
        lat_min = 1; lat_max = 2;
        redirect_and_follow(1, 32'hFFFF_FFFE, 32'hFFFF_FFFC);
        n_tests++; if (exp_pres >= 32'hFFFF_FFFC || exp_pres < 32'h8) begin n_fail++; $display("FAIL wrap_progress got exp_pres=%h want small wrapped value", exp_pres); end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        logic [31:0] first_pc;
        bit got_first = 0;
        lat_min = 3; lat_max = 3;
        while (mq_addr.size() < 2 && guard < 20) begin begin_cycle(1, 1, 0, 0); end_cycle(); guard++; end
        rst = 1'b0;
        begin_cycle(1, 1, 0, 0); end_cycle();
        rst = 1'b1;
        flush_mem();
        begin_cycle(1, 1, 0, 0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hBAD0_BAD0;
        #1;
        n_tests++; if (bus.imem_req_valid !== 1'b0 || bus.if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_outs got rv=%b iv=%b want 0,0", bus.imem_req_valid, bus.if_id_valid); end
        n_tests++; if (bus.if_id_pc !== 32'h0 || bus.if_id_instruction !== NOP) begin n_fail++; $display("FAIL rmid_vals got pc=%h i=%h want 0,%h", bus.if_id_pc, bus.if_id_instruction, NOP); end
        end_cycle();
        for (int c = 0; c < 15; c++) begin
            begin_cycle(1, 1, 0, 0);
            if (c == 0) begin
                n_tests++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL rmid_restart got v=%b a=%h want v=1 a=0", bus.imem_req_valid, bus.imem_req_addr); end
            end
            if (bus.if_id_valid === 1'b1 && !got_first) begin got_first = 1; first_pc = bus.if_id_pc; end
            n_tests++; if (bus.if_id_valid === 1'b1 && (bus.if_id_pc !== exp_pres || bus.if_id_instruction !== memf(exp_pres))) begin n_fail++; $display("FAIL rmid_stream got pc=%h i=%h want pc=%h", bus.if_id_pc, bus.if_id_instruction, exp_pres); end
            end_cycle();
        end
        n_tests++; if (!got_first || first_pc !== 32'h0) begin n_fail++; $display("FAIL rmid_first got seen=%0d pc=%h want pc=0", got_first, first_pc); end
    endtask

    task automatic test_random();
        bit pv = 0, pr = 0;
        logic [31:0] pa = '0;
        lat_min = 1; lat_max = 4;
        for (int c = 0; c < 400; c++) begin
            bit rdy, idr, rv;
            rdy = ($urandom_range(9, 0) < 7);
            idr = ($urandom_range(9, 0) < 7);
            rv  = ($urandom_range(19, 0) == 0);
            begin_cycle(rdy, idr, rv, $urandom);
            n_tests++; if (bus.if_id_valid === 1'b1 && (bus.if_id_pc !== exp_pres || bus.if_id_instruction !== memf(exp_pres))) begin n_fail++; $display("FAIL rnd_head c=%0d got pc=%h i=%h want pc=%h", c, bus.if_id_pc, bus.if_id_instruction, exp_pres); end
            n_tests++; if (bus.if_id_valid !== 1'b1 && bus.if_id_instruction !== NOP) begin n_fail++; $display("FAIL rnd_nop c=%0d got %h want %h", c, bus.if_id_instruction, NOP); end
            n_tests++; if (bus.imem_req_valid === 1'b1 && bus.imem_req_addr !== exp_fetch) begin n_fail++; $display("FAIL rnd_req_addr c=%0d got %h want %h", c, bus.imem_req_addr, exp_fetch); end
            n_tests++; if (rv && (bus.imem_req_valid !== 1'b0 || bus.if_id_valid !== 1'b0)) begin n_fail++; $display("FAIL rnd_redir_quiet c=%0d got rv=%b iv=%b want 0,0", c, bus.imem_req_valid, bus.if_id_valid); end
            n_tests++; if (pv && !pr && !rv && (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== pa)) begin n_fail++; $display("FAIL rnd_req_stable c=%0d got v=%b a=%h want v=1 a=%h", c, bus.imem_req_valid, bus.imem_req_addr, pa); end
            n_tests++; if (mq_addr.size() > D) begin n_fail++; $display("FAIL rnd_inflight c=%0d got %0d want <=%0d", c, mq_addr.size(), D); end
            pv = (bus.imem_req_valid === 1'b1);
            pr = rdy;
            pa = bus.imem_req_addr;
            end_cycle();
        end
    endtask

    initial begin
        exp_fetch = '0;
        exp_pres  = '0;
        test_reset();
        test_backpressure();
        test_redirect();
        test_redirect_rsp();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
